// File: rtl/rtc_seq_pkg.sv
// rtl/rtc_seq_pkg.sv - shared types and constants for the RTC BCD write sequencer
//
// Purpose: state encoding, RTC field indices, converter invalid marker and
//          default register-map parameters used by rtc_bcd_write_seq.
// Ports:   none (package).
package rtc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int F_SEC   = 0;
  localparam int F_MIN   = 1;
  localparam int F_HOUR  = 2;
  localparam int F_DAY   = 3;
  localparam int F_MONTH = 4;
  localparam int F_YEAR  = 5;

  localparam int         DEFAULT_NUM_FIELDS  = 6;
  localparam logic [7:0] DEFAULT_BASE_ADDR   = 8'h21;
  localparam int         DEFAULT_ADDR_STRIDE = 1;

  // Converter result meaning "operand out of range".
  localparam logic [7:0] BCD_INVALID = 8'hFF;

endpackage

// File: rtl/rtc_bcd_write_seq.sv
// rtl/rtc_bcd_write_seq.sv - sequences a shared binary-to-BCD converter over RTC fields and writes results
//
// Purpose: on start, latch all binary time/date fields, then for each field
//          drive the shared converter, capture its BCD result and write it
//          to the RTC register bus over a req/ack handshake.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start                one-cycle request, honoured only when idle
//   field_bin            packed binary fields, field i at [7i+6:7i]
//   conv_bin / conv_bcd  operand to / result from the external converter
//   wr_req/wr_addr/wr_data/wr_ack  register bus write handshake
//   busy, done, err      sequence status; err is sticky per sequence
// Configuration macro: RTC_SEQ_SKIP_INVALID_EN
//   defined   - invalid fields are skipped and the sequence continues
//   undefined - the first invalid field ends the sequence
module rtc_bcd_write_seq
  import rtc_seq_pkg::*;
#(
  parameter int         NUM_FIELDS  = DEFAULT_NUM_FIELDS,
  parameter logic [7:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int         ADDR_STRIDE = DEFAULT_ADDR_STRIDE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [7*NUM_FIELDS-1:0] field_bin,
  output logic [6:0]              conv_bin,
  input  logic [7:0]              conv_bcd,
  output logic                    wr_req,
  output logic [7:0]              wr_addr,
  output logic [7:0]              wr_data,
  input  logic                    wr_ack,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int                IDX_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        idx;
  logic [7*NUM_FIELDS-1:0] fields_q;
  logic [6:0]              field_sel;
  logic                    is_last;

  // Mux the latched copy so mid-sequence input changes cannot leak in.
  always_comb begin
    field_sel = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (idx == IDX_W'(i)) begin
        field_sel = fields_q[7*i +: 7];
      end
    end
  end

  assign is_last = (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CONV;
      end
      ST_CONV: begin
        if (conv_bcd == BCD_INVALID) begin
`ifdef RTC_SEQ_SKIP_INVALID_EN
          state_nxt = is_last ? ST_DONE : ST_CONV;
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_ack) state_nxt = is_last ? ST_DONE : ST_CONV;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: field latch, index, write address/data capture, sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fields_q <= '0;
      idx      <= '0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            fields_q <= field_bin;
            idx      <= '0;
            err      <= 1'b0;
          end
        end
        ST_CONV: begin
          // Address arithmetic wraps in 8 bits by construction.
          wr_addr <= BASE_ADDR + 8'(ADDR_STRIDE) * 8'(idx);
          wr_data <= conv_bcd;
          if (conv_bcd == BCD_INVALID) begin
            err <= 1'b1;
`ifdef RTC_SEQ_SKIP_INVALID_EN
            if (!is_last) idx <= idx + 1'b1;
`endif
          end
        end
        ST_WRITE: begin
          if (wr_ack && !is_last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so reset drops wr_req without waiting for a clock.
  always_comb begin
    busy     = (state != ST_IDLE);
    wr_req   = (state == ST_WRITE);
    done     = (state == ST_DONE);
    // The converter is shared: only drive it while this sequencer owns it.
    conv_bin = busy ? field_sel : 7'd0;
  end

endmodule

// File: tb/tb_rtc_bcd_write_seq.sv
// tb/tb_rtc_bcd_write_seq.sv - self-checking bench for rtc_bcd_write_seq
//
// Purpose: directed sequences against a write-list model of the sequencer,
//          with an in-bench binary-to-BCD converter on conv_bin/conv_bcd.
// Ports:   none (top-level bench). Honours RTC_SEQ_SKIP_INVALID_EN.
module tb_rtc_bcd_write_seq;
  import rtc_seq_pkg::*;

  localparam int N = 6;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic [7*N-1:0] field_bin = '0;
  logic [6:0]     conv_bin;
  logic [7:0]     conv_bcd;
  logic           wr_req;
  logic [7:0]     wr_addr;
  logic [7:0]     wr_data;
  logic           wr_ack = 1'b0;
  logic           busy;
  logic           done;
  logic           err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rtc_bcd_write_seq #(.NUM_FIELDS(N), .BASE_ADDR(8'h21), .ADDR_STRIDE(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .field_bin(field_bin),
    .conv_bin(conv_bin), .conv_bcd(conv_bcd), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy), .done(done), .err(err)
  );

  // External converter: two BCD digits for 0..99, invalid marker otherwise.
  function automatic logic [7:0] to_bcd(input int v);
    if (v >= 0 && v < 100) return {4'(v / 10), 4'(v % 10)};
    return 8'hFF;
  endfunction
  assign conv_bcd = to_bcd(int'(conv_bin));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7*N-1:0] pack6(input int a0, a1, a2, a3, a4, a5);
    return {7'(a5), 7'(a4), 7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  // Model: the list of writes a sequence must produce and its final err.
  logic [7:0] exp_addr_q[$];
  logic [7:0] exp_data_q[$];
  logic [7:0] got_addr_q[$];
  logic [7:0] got_data_q[$];
  logic       exp_err = 1'b0;

  task automatic model_start(input logic [7*N-1:0] f);
    bit stopped;
    stopped = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete();
    got_addr_q.delete(); got_data_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      int v;
      v = int'(f[7*i +: 7]);
      if (!stopped) begin
        if (v >= 100) begin
          exp_err = 1'b1;
`ifndef RTC_SEQ_SKIP_INVALID_EN
          stopped = 1'b1;
`endif
        end else begin
          exp_addr_q.push_back(8'(8'h21 + i));
          exp_data_q.push_back(8'((v / 10) * 16 + (v % 10)));
        end
      end
    end
  endtask

  // Compare process plus bus-side ack generation.
  int         ack_delay = 0;
  int         req_cnt = 0;
  int         ncnt = 0;
  int         done_cnt = 0;
  int         done_neg = 0;
  logic       prev_req = 1'b0;
  logic       prev_acc = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    ncnt++;
    if (!busy) check("conv_bin_idle", 32'(conv_bin), 32'd0);
    if (wr_req && prev_req && !prev_acc) begin
      check("wr_addr_stable", 32'(wr_addr), 32'(prev_addr));
      check("wr_data_stable", 32'(wr_data), 32'(prev_data));
    end
    if (done) begin
      done_cnt++;
      done_neg = ncnt;
      check("err_at_done", 32'(err), 32'(exp_err));
      check("writes_left_at_done", 32'(exp_addr_q.size()), 32'd0);
    end
    if (ack_delay == 0) begin
      wr_ack = 1'b1;
    end else begin
      if (wr_req) req_cnt++;
      wr_ack = wr_req && (req_cnt > ack_delay);
    end
    prev_acc = wr_req && wr_ack;
    if (prev_acc) begin
      got_addr_q.push_back(wr_addr);
      got_data_q.push_back(wr_data);
      check("write_expected", 32'(exp_addr_q.size() > 0), 32'd1);
      if (exp_addr_q.size() > 0) begin
        check("wr_addr", 32'(wr_addr), 32'(exp_addr_q.pop_front()));
        check("wr_data", 32'(wr_data), 32'(exp_data_q.pop_front()));
      end
      req_cnt = 0;
    end
    prev_req  = wr_req;
    prev_addr = wr_addr;
    prev_data = wr_data;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int start_neg = 0;

  task automatic run_seq(input logic [7*N-1:0] f, input int dly);
    ack_delay = dly;
    field_bin = f;
    model_start(f);
    start = 1'b1;
    start_neg = ncnt;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int dc0);
    int k;
    k = 0;
    while (done_cnt == dc0 && k < 300) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != dc0), 32'd1);
    tick();
  endtask

  initial begin
    int dc;
    int k;
    logic [7:0] lit;

    // Reset state
    tick(); tick();
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_conv_bin", 32'(conv_bin), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    tick();

    // T1: all fields 5, ack tied high
    dc = done_cnt;
    run_seq(pack6(5, 5, 5, 5, 5, 5), 0);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    wait_done("t1", dc);
    check("t1_latency", 32'(done_neg - start_neg + 1), 32'd14);
    check("t1_write_count", 32'(got_data_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_data_q.size(); i++) begin
      lit = 8'h21 + 8'(i);
      check("t1_lit_addr", 32'(got_addr_q[i]), 32'(lit));
      check("t1_lit_data", 32'(got_data_q[i]), 32'h05);
    end
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // T2: ack delayed 3 cycles per write
    dc = done_cnt;
    run_seq(pack6(0, 1, 2, 3, 4, 9), 3);
    wait_done("t2", dc);
    check("t2_write_count", 32'(got_data_q.size()), 32'd6);
    if (got_data_q.size() == 6) begin
      check("t2_lit_data3", 32'(got_data_q[3]), 32'h03);
      check("t2_lit_data5", 32'(got_data_q[5]), 32'h09);
    end

    // T3: field 2 out of range
    dc = done_cnt;
    run_seq(pack6(10, 20, 100, 30, 40, 50), 0);
    wait_done("t3", dc);
`ifdef RTC_SEQ_SKIP_INVALID_EN
    check("t3_write_count", 32'(got_data_q.size()), 32'd5);
`else
    check("t3_write_count", 32'(got_data_q.size()), 32'd2);
`endif
    check("t3_err_sticky", 32'(err), 32'd1);

    // T4: start re-pulsed and fields changed mid-sequence
    dc = done_cnt;
    run_seq(pack6(11, 12, 13, 14, 15, 16), 1);
    tick(); tick(); tick();
    field_bin = pack6(99, 98, 97, 96, 95, 94);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t4", dc);
    check("t4_write_count", 32'(got_data_q.size()), 32'd6);
    if (got_data_q.size() == 6) check("t4_lit_data5", 32'(got_data_q[5]), 32'h16);
    check("t4_single_done", 32'(done_cnt - dc), 32'd1);

    // T5: reset during WRITE of field 3
    run_seq(pack6(7, 8, 9, 10, 11, 12), 2);
    k = 0;
    while (!(wr_req && wr_addr == 8'h24) && k < 200) begin
      tick();
      k++;
    end
    check("t5_reached_field3", 32'(wr_req && wr_addr == 8'h24), 32'd1);
    dc = done_cnt;
    reset_n = 1'b0;
    #1;
    check("t5_wr_req_async", 32'(wr_req), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    check("t5_wr_addr", 32'(wr_addr), 32'd0);
    check("t5_wr_data", 32'(wr_data), 32'd0);
    check("t5_conv_bin", 32'(conv_bin), 32'd0);
    tick(); tick(); tick();
    reset_n = 1'b1;
    req_cnt = 0;
    tick(); tick();
    check("t5_no_done", 32'(done_cnt - dc), 32'd0);
    dc = done_cnt;
    run_seq(pack6(21, 22, 23, 24, 25, 26), 0);
    wait_done("t5_clean", dc);
    check("t5_clean_count", 32'(got_data_q.size()), 32'd6);

    // T6: back-to-back; first sequence errors, second must clear err
    dc = done_cnt;
    run_seq(pack6(120, 1, 2, 3, 4, 5), 0);
    wait_done("t6a", dc);
    check("t6a_err", 32'(err), 32'd1);
    dc = done_cnt;
    run_seq(pack6(59, 59, 23, 31, 12, 99), 0);
    check("t6b_busy", 32'(busy), 32'd1);
    check("t6b_err_cleared", 32'(err), 32'd0);
    wait_done("t6b", dc);
    check("t6b_write_count", 32'(got_data_q.size()), 32'd6);
    if (got_data_q.size() == 6) check("t6b_lit_data0", 32'(got_data_q[0]), 32'h59);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
